pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised successor to the core's program-counter block. Holds the fetch PC and selects the next PC with fixed priority: mret, then interrupt, then jump/branch, then sequential. It offers the PC to the fetch stage over a valid/ready handshake and tags each PC with a redirect epoch so wrong-path fetches can be killed. It also adds a boot state, halt/wake, vectored interrupt targets and misaligned-target reporting.

Parameters:
XLEN, 32, PC and target width
PC_INC, 4, sequential increment in bytes
EPOCH_W, 2, epoch tag width
VECTORED_EN, 1, 1 = allow vectored interrupt targets (mtvec MODE bit 0)
CAUSE_W, 5, interrupt cause width

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
enable_design  in  1  global enable; 0 freezes the block
initial_pc_i  in  XLEN  boot PC, sampled on leaving BOOT
halt_i  in  1  level request to stop fetching
pc_ready_i  in  1  fetch stage accepts offered PC
pc_o  out  XLEN  current fetch PC
pc_valid_o  out  1  pc_o is offered
epoch_o  out  EPOCH_W  epoch of pc_o
fetch_flush_o  out  1  redirect applied this cycle
jump_inst_i  in  1  jump redirect request
branch_inst_i  in  1  taken-branch redirect request
target_pc_i  in  XLEN  jump/branch target
mret_inst_i  in  1  return from trap
mepc_i  in  XLEN  mret target
irq_prep_i  in  1  take interrupt
mtvec_i  in  XLEN  trap vector; bit 0 is MODE
irq_cause_i  in  CAUSE_W  interrupt cause
target_misaligned_o  out  1  jump/branch target had bits[1:0] != 0
halted_o  out  1  FSM in HALT

Behaviour:
- Reset (async assert, sync release): state=BOOT, pc_o=0, epoch_o=0; all 1-bit outputs 0.
- enable_design=0: state, PC and epoch hold. pc_valid_o=0, fetch_flush_o=0, target_misaligned_o=0. All redirect inputs are ignored.
- FSM states BOOT, RUN, HALT:
  - BOOT: pc_valid_o=0 and redirects are ignored. On the first enabled cycle, PC <= initial_pc_i and state goes to RUN. There is no epoch change and no flush.
  - RUN: pc_valid_o=1.
    - An active redirect is applied (see below).
    - Otherwise, if halt_i=1, state goes to HALT with PC held.
    - Otherwise, if pc_ready_i=1, PC <= PC + PC_INC (mod 2^XLEN, wraps at top).
    - Otherwise PC holds and pc_o stays stable.
  - HALT: pc_valid_o=0, halted_o=1.
    - irq_prep_i or mret_inst_i applies that redirect and goes to RUN.
    - jump/branch is applied but the state stays in HALT.
    - halt_i=0 with no redirect goes to RUN and PC holds.
- Redirect selection. The target is registered into PC on the next edge.
  - mret_inst_i: target = mepc_i.
  - else irq_prep_i: if VECTORED_EN and mtvec_i[0], target = {mtvec_i[XLEN-1:2],2'b00} + 4*irq_cause_i; otherwise target = {mtvec_i[XLEN-1:2],2'b00}.
  - else jump_inst_i | branch_inst_i: target = {target_pc_i[XLEN-1:2],2'b00}. target_misaligned_o is a combinational pulse in the same cycle if target_pc_i[1:0] != 0 and this source is selected.
- Any applied redirect: fetch_flush_o=1 combinationally that cycle, and epoch_o increments (wraps mod 2^EPOCH_W) on the same edge as the PC load.
- A redirect overrides pc_ready_i. If the handshake also completes that cycle, the transfer stands (old epoch); the downstream stage drops it via epoch mismatch.
- Handshake rule: pc_o and epoch_o are stable while pc_valid_o=1 and pc_ready_i=0. The only exception is a redirect, which is announced by fetch_flush_o.
- Reset mid-operation: returns to BOOT immediately, and the previous epoch is lost.
- Latency: redirect input to new pc_o is 1 cycle. Accept to next sequential pc_o is 1 cycle.

Decomposition:
- Shared package: XLEN default, PC_INC, FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), mtvec MODE bit index.
- One sub-module, pc_redirect_sel: combinational priority mux and vector computation, producing target, redirect valid and misaligned flag.
- The FSM, PC and epoch registers stay in pc_sequencer.

Test Plan:
- Reset, then enable with initial_pc_i=0x1CC and pc_ready_i=1 for 3 cycles -> pc_o 0x1CC, 0x1D0, 0x1D4; epoch_o=0; pc_valid_o low in the BOOT cycle.
- pc_ready_i=0 for 4 cycles at PC 0x200 -> pc_o holds 0x200 with pc_valid_o=1; ready high -> 0x204 next cycle.
- Same cycle jump to 0x300, irq_prep_i, mret_inst_i with mepc_i=0x80 -> next pc_o 0x80, fetch_flush_o pulse, epoch_o 0 to 1.
- irq with mtvec_i=0x1001 and irq_cause_i=7, VECTORED_EN=1 -> pc_o 0x101C. Same with mtvec_i=0x1000 -> 0x1000.
- Branch target 0x402 -> target_misaligned_o=1 that cycle, pc_o 0x400 next. Four redirects from epoch 3 -> epoch wraps 3 to 0 on the first.
- halt_i=1 in RUN -> halted_o=1, pc_valid_o=0. irq_prep_i -> RUN at vector. Separately, assert reset_ni low mid-run -> outputs 0 asynchronously, state BOOT.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: default widths,
// FSM state encoding and the mtvec MODE bit location.
package pc_sequencer_pkg;

    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned PC_INC_DEF     = 4;
    localparam int unsigned EPOCH_W_DEF    = 2;
    localparam int unsigned CAUSE_W_DEF    = 5;
    localparam int unsigned MTVEC_MODE_BIT = 0;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_sel.sv
// Fixed-priority redirect selection: mret, then interrupt (optionally
// vectored), then jump/branch. Purely combinational.
module pc_redirect_sel
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned CAUSE_W     = CAUSE_W_DEF,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic               mret_inst,
    input  logic [XLEN-1:0]    mepc,
    input  logic               irq_prep,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [CAUSE_W-1:0] irq_cause,
    input  logic               jump_inst,
    input  logic               branch_inst,
    input  logic [XLEN-1:0]    target_pc,
    output logic [XLEN-1:0]    target,
    output logic               redir_valid,
    output logic               is_trap,
    output logic               misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(2'b11);

    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] vec_base_s;
    logic            redir_valid_s;
    logic            is_trap_s;
    logic            misaligned_s;

    assign vec_base_s = mtvec & ALIGN_MASK;

    // Priority mux over redirect sources
    always_comb begin
        target_s      = '0;
        redir_valid_s = 1'b0;
        is_trap_s     = 1'b0;
        misaligned_s  = 1'b0;
        if (mret_inst) begin
            target_s      = mepc;
            redir_valid_s = 1'b1;
            is_trap_s     = 1'b1;
        end else if (irq_prep) begin
            redir_valid_s = 1'b1;
            is_trap_s     = 1'b1;
            if (VECTORED_EN && mtvec[MTVEC_MODE_BIT]) begin
                target_s = vec_base_s + XLEN'({irq_cause, 2'b00});
            end else begin
                target_s = vec_base_s;
            end
        end else if (jump_inst || branch_inst) begin
            target_s      = target_pc & ALIGN_MASK;
            redir_valid_s = 1'b1;
            misaligned_s  = (target_pc[1:0] != 2'b00);
        end else begin
            target_s      = '0;
            redir_valid_s = 1'b0;
        end
    end

    assign target      = target_s;
    assign redir_valid = redir_valid_s;
    assign is_trap     = is_trap_s;
    assign misaligned  = misaligned_s;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT FSM, PC and redirect-epoch registers,
// valid/ready offer of the PC to the fetch stage.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned PC_INC      = PC_INC_DEF,
    parameter int unsigned EPOCH_W     = EPOCH_W_DEF,
    parameter bit          VECTORED_EN = 1'b1,
    parameter int unsigned CAUSE_W     = CAUSE_W_DEF
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               enable_design,
    input  logic [XLEN-1:0]    initial_pc_i,
    input  logic               halt_i,
    input  logic               pc_ready_i,
    output logic [XLEN-1:0]    pc_o,
    output logic               pc_valid_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               fetch_flush_o,
    input  logic               jump_inst_i,
    input  logic               branch_inst_i,
    input  logic [XLEN-1:0]    target_pc_i,
    input  logic               mret_inst_i,
    input  logic [XLEN-1:0]    mepc_i,
    input  logic               irq_prep_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [CAUSE_W-1:0] irq_cause_i,
    output logic               target_misaligned_o,
    output logic               halted_o
);

    pc_state_e         state_r;
    logic [XLEN-1:0]   pc_r;
    logic [EPOCH_W-1:0] epoch_r;

    logic [XLEN-1:0]   target_s;
    logic              redir_valid_s;
    logic              is_trap_s;
    logic              misaligned_s;
    logic              apply_s;

    pc_redirect_sel #(
        .XLEN        (XLEN),
        .CAUSE_W     (CAUSE_W),
        .VECTORED_EN (VECTORED_EN)
    ) u_redirect_sel (
        .mret_inst   (mret_inst_i),
        .mepc        (mepc_i),
        .irq_prep    (irq_prep_i),
        .mtvec       (mtvec_i),
        .irq_cause   (irq_cause_i),
        .jump_inst   (jump_inst_i),
        .branch_inst (branch_inst_i),
        .target_pc   (target_pc_i),
        .target      (target_s),
        .redir_valid (redir_valid_s),
        .is_trap     (is_trap_s),
        .misaligned  (misaligned_s)
    );

    // Redirects only take effect once out of BOOT and while enabled
    always_comb begin
        apply_s = 1'b0;
        if (enable_design && (state_r != ST_BOOT)) begin
            apply_s = redir_valid_s;
        end else begin
            apply_s = 1'b0;
        end
    end

    // Sequencer FSM with PC and epoch registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= ST_BOOT;
            pc_r    <= '0;
            epoch_r <= '0;
        end else if (enable_design) begin
            case (state_r)
                ST_BOOT: begin
                    pc_r    <= initial_pc_i;
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (redir_valid_s) begin
                        pc_r    <= target_s;
                        epoch_r <= epoch_r + EPOCH_W'(1'b1);
                    end else if (halt_i) begin
                        state_r <= ST_HALT;
                    end else if (pc_ready_i) begin
                        pc_r <= pc_r + XLEN'(PC_INC);
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_HALT: begin
                    // Jump/branch retargets a halted core without waking it
                    if (redir_valid_s) begin
                        pc_r    <= target_s;
                        epoch_r <= epoch_r + EPOCH_W'(1'b1);
                        if (is_trap_s) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_HALT;
                        end
                    end else if (!halt_i) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                default: begin
                    state_r <= ST_BOOT;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign pc_o                = pc_r;
    assign epoch_o             = epoch_r;
    assign pc_valid_o          = enable_design && (state_r == ST_RUN);
    assign halted_o            = (state_r == ST_HALT);
    assign fetch_flush_o       = apply_s;
    assign target_misaligned_o = apply_s && misaligned_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a scoreboard queue of expected
// post-edge PC/epoch values.
module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        enable_design;
    logic [31:0] initial_pc_i;
    logic        halt_i;
    logic        pc_ready_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic [1:0]  epoch_o;
    logic        fetch_flush_o;
    logic        jump_inst_i;
    logic        branch_inst_i;
    logic [31:0] target_pc_i;
    logic        mret_inst_i;
    logic [31:0] mepc_i;
    logic        irq_prep_i;
    logic [31:0] mtvec_i;
    logic [4:0]  irq_cause_i;
    logic        target_misaligned_o;
    logic        halted_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  ep;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    pc_sequencer dut (
        .clk_i               (clk_i),
        .reset_ni            (reset_ni),
        .enable_design       (enable_design),
        .initial_pc_i        (initial_pc_i),
        .halt_i              (halt_i),
        .pc_ready_i          (pc_ready_i),
        .pc_o                (pc_o),
        .pc_valid_o          (pc_valid_o),
        .epoch_o             (epoch_o),
        .fetch_flush_o       (fetch_flush_o),
        .jump_inst_i         (jump_inst_i),
        .branch_inst_i       (branch_inst_i),
        .target_pc_i         (target_pc_i),
        .mret_inst_i         (mret_inst_i),
        .mepc_i              (mepc_i),
        .irq_prep_i          (irq_prep_i),
        .mtvec_i             (mtvec_i),
        .irq_cause_i         (irq_cause_i),
        .target_misaligned_o (target_misaligned_o),
        .halted_o            (halted_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [1:0] ep);
        exp_t e;
        e.pc = pc;
        e.ep = ep;
        sb_q.push_back(e);
    endtask

    // advance one clock and compare against the oldest expectation
    task automatic cyc(input string tag);
        exp_t e;
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_pc"}, pc_o, e.pc);
            chk({tag, "_epoch"}, {30'd0, epoch_o}, {30'd0, e.ep});
        end
    endtask

    task automatic clr_redir();
        jump_inst_i   = 1'b0;
        branch_inst_i = 1'b0;
        mret_inst_i   = 1'b0;
        irq_prep_i    = 1'b0;
    endtask

    initial begin
        reset_ni      = 1'b0;
        enable_design = 1'b0;
        initial_pc_i  = 32'h0;
        halt_i        = 1'b0;
        pc_ready_i    = 1'b0;
        target_pc_i   = 32'h0;
        mepc_i        = 32'h0;
        mtvec_i       = 32'h0;
        irq_cause_i   = 5'd0;
        clr_redir();

        #12;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_epoch", {30'd0, epoch_o}, 32'd0);
        chk("rst_bits", {28'd0, pc_valid_o, fetch_flush_o, target_misaligned_o, halted_o}, 32'd0);
        #1 reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // boot and sequential fetch
        enable_design = 1'b1;
        initial_pc_i  = 32'h1CC;
        pc_ready_i    = 1'b1;
        #1;
        chk("boot_valid", {31'd0, pc_valid_o}, 32'd0);
        push(32'h1CC, 2'd0); cyc("boot");
        chk("run_valid", {31'd0, pc_valid_o}, 32'd1);
        push(32'h1D0, 2'd0); cyc("seq1");
        push(32'h1D4, 2'd0); cyc("seq2");

        // async reset, re-boot at 0x200, stall with ready low
        reset_ni = 1'b0;
        #1;
        chk("areset_pc", pc_o, 32'h0);
        chk("areset_valid", {31'd0, pc_valid_o}, 32'd0);
        #1 reset_ni = 1'b1;
        initial_pc_i = 32'h200;
        pc_ready_i   = 1'b0;
        push(32'h200, 2'd0); cyc("reboot");
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {31'd0, pc_valid_o}, 32'd1);
            push(32'h200, 2'd0); cyc("stall");
        end
        pc_ready_i = 1'b1;
        push(32'h204, 2'd0); cyc("accept");

        // all sources at once: mret wins
        jump_inst_i = 1'b1; target_pc_i = 32'h300;
        irq_prep_i  = 1'b1; mtvec_i = 32'h1001; irq_cause_i = 5'd7;
        mret_inst_i = 1'b1; mepc_i = 32'h80;
        #1;
        chk("prio_flush", {31'd0, fetch_flush_o}, 32'd1);
        chk("prio_mis", {31'd0, target_misaligned_o}, 32'd0);
        push(32'h80, 2'd1); cyc("prio");
        clr_redir();
        #1;
        chk("flush_clear", {31'd0, fetch_flush_o}, 32'd0);

        // vectored and direct interrupt targets
        irq_prep_i = 1'b1; mtvec_i = 32'h1001; irq_cause_i = 5'd7;
        push(32'h101C, 2'd2); cyc("irq_vec");
        mtvec_i = 32'h1000;
        push(32'h1000, 2'd3); cyc("irq_dir");
        clr_redir();

        // misaligned branch, then epoch wrap across four redirects
        branch_inst_i = 1'b1; target_pc_i = 32'h402;
        #1;
        chk("mis_pulse", {31'd0, target_misaligned_o}, 32'd1);
        push(32'h400, 2'd0); cyc("branch");
        branch_inst_i = 1'b0;
        jump_inst_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            target_pc_i = 32'h400 + 32'(i) * 32'h100;
            push(32'h400 + 32'(i) * 32'h100, 2'(i)); cyc("jump_ep");
        end
        clr_redir();

        // halt, jump while halted, wake by interrupt
        halt_i = 1'b1;
        push(32'h700, 2'd3); cyc("halt_enter");
        chk("halted", {30'd0, halted_o, pc_valid_o}, 32'd2);
        pc_ready_i = 1'b0;
        jump_inst_i = 1'b1; target_pc_i = 32'h800;
        push(32'h800, 2'd0); cyc("halt_jump");
        chk("halt_stays", {31'd0, halted_o}, 32'd1);
        jump_inst_i = 1'b0;
        irq_prep_i = 1'b1; mtvec_i = 32'h2001; irq_cause_i = 5'd3;
        push(32'h200C, 2'd1); cyc("halt_irq");
        chk("irq_wake", {30'd0, halted_o, pc_valid_o}, 32'd1);
        clr_redir();

        // halt then release via halt_i=0
        push(32'h200C, 2'd1); cyc("halt2");
        halt_i = 1'b0;
        push(32'h200C, 2'd1); cyc("wake");
        chk("wake_state", {30'd0, halted_o, pc_valid_o}, 32'd1);

        // disabled: redirects ignored, outputs quiet
        enable_design = 1'b0;
        pc_ready_i = 1'b1;
        jump_inst_i = 1'b1; target_pc_i = 32'h901;
        #1;
        chk("dis_bits", {29'd0, pc_valid_o, fetch_flush_o, target_misaligned_o}, 32'd0);
        push(32'h200C, 2'd1); cyc("disabled");
        enable_design = 1'b1;
        jump_inst_i = 1'b0;
        push(32'h2010, 2'd1); cyc("reenable");

        // PC wrap at the top of the address space
        jump_inst_i = 1'b1; target_pc_i = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC, 2'd2); cyc("top");
        jump_inst_i = 1'b0;
        push(32'h0, 2'd2); cyc("wrap");

        // reset mid-run loses the epoch immediately
        #2 reset_ni = 1'b0;
        #1;
        chk("mid_rst_epoch", {30'd0, epoch_o}, 32'd0);
        chk("mid_rst_bits", {30'd0, pc_valid_o, halted_o}, 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
